// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state type, matrix size and the column reset pattern.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

    typedef enum logic {
        SCAN = 1'b0,
        HELD = 1'b1
    } scan_state_t;

    // One-hot of the lowest-index low bit; row 0 has highest priority.
    function automatic logic [NUM_ROWS-1:0] lowest_low(
        input logic [NUM_ROWS-1:0] v
    );
        logic [NUM_ROWS-1:0] h;
        h = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!v[i]) begin
                h    = '0;
                h[i] = 1'b1;
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Multi-stage synchronizer for the asynchronous keypad row lines.
// Ports: clk_i, rst_ni (async active-low), row_i (raw rows), srow_o (synced rows).
module row_sync
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_ROWS-1:0] srow_o
);

    // Reset to all ones so an idle (pulled-up) keypad is seen from reset.
    logic [SYNC_STAGES-1:0][NUM_ROWS-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], row_i};
        end
    end

    assign srow_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: walks an active-low column, locks the first key.
// Ports: clk, reset (async active-low), row[3:0] in; col, keypad_val, button_on out.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_ROWS-1:0]          row,
    output logic [NUM_COLS-1:0]          col,
    output logic [NUM_ROWS+NUM_COLS-1:0] keypad_val,
    output logic                         button_on
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [NUM_ROWS-1:0] srow;

    scan_state_t                  state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_COLS-1:0]          col_q, col_d;
    logic [NUM_ROWS-1:0]          rhot_q, rhot_d;
    logic [NUM_ROWS+NUM_COLS-1:0] kv_q, kv_d;
    logic                         bo_q, bo_d;
    logic [NUM_ROWS-1:0]          hit;
    logic                         released;

    row_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_row_sync (
        .clk_i (clk),
        .rst_ni(reset),
        .row_i (row),
        .srow_o(srow)
    );

    assign hit = lowest_low(srow);

    // Only the locked row is watched while a key is held.
    assign released = ~|(~srow & rhot_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        rhot_d  = rhot_q;
        kv_d    = kv_q;
        bo_d    = bo_q;
        unique case (state_q)
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (&srow) begin
                        col_d = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                    end else begin
                        state_d = HELD;
                        rhot_d  = hit;
                        kv_d    = {hit, ~col_q};
                        bo_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (released) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    col_d   = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
                    rhot_d  = '0;
                    kv_d    = '0;
                    bo_d    = 1'b0;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= COL_IDLE;
            rhot_q  <= '0;
            kv_q    <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            rhot_q  <= rhot_d;
            kv_q    <= kv_d;
            bo_q    <= bo_d;
        end
    end

    assign col        = col_q;
    assign keypad_val = kv_q;
    assign button_on  = bo_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 keypad model.
// Output events (button_on/keypad_val changes) are popped and compared.
module tb_keypad_scanner;

    typedef struct packed {
        logic [3:0] col;
        logic [7:0] kv;
        logic       bo;
    } snap_t;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] keypad_val;
    logic       button_on;

    logic [3:0][3:0] key;
    logic [3:0]      glitch;

    int    checks;
    int    fails;
    snap_t exp_q[$];
    snap_t e_s;
    snap_t a_s;
    logic  mon_en;
    logic [8:0] prev;
    logic [3:0] pat [4];
    int    n;

    keypad_scanner #(
        .SETTLE_CYCLES(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .keypad_val(keypad_val),
        .button_on (button_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~(|(key[r] & ~col)) & ~glitch[r];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (($countones(~col) != 1) || (!button_on && keypad_val != 8'h00)) begin
                fails++;
                $display("FAIL invariant col=%b kv=%h bo=%b", col, keypad_val, button_on);
            end
            if ({button_on, keypad_val} !== prev) begin
                prev = {button_on, keypad_val};
                a_s  = '{col, keypad_val, button_on};
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event got col=%b kv=%h bo=%b",
                             col, keypad_val, button_on);
                end else begin
                    e_s = exp_q.pop_front();
                    if (a_s !== e_s) begin
                        fails++;
                        $display("FAIL event got col=%b kv=%h bo=%b exp col=%b kv=%h bo=%b",
                                 a_s.col, a_s.kv, a_s.bo, e_s.col, e_s.kv, e_s.bo);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_bo(input string name, input logic v, input int limit, output int cyc);
        cyc = 0;
        while (button_on !== v && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (button_on !== v) begin
            fails++;
            $display("FAIL %s timeout got bo=%b exp=%b", name, button_on, v);
        end
    endtask

    task automatic expect_ev(input logic [3:0] c, input logic [7:0] kv, input logic bo);
        snap_t s;
        s = '{c, kv, bo};
        exp_q.push_back(s);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        fails  = 0;
        mon_en = 1'b0;
        prev   = '0;
        key    = '0;
        glitch = '0;
        reset  = 1'b0;
        pat[0] = 4'b1110;
        pat[1] = 4'b1101;
        pat[2] = 4'b1011;
        pat[3] = 4'b0111;

        repeat (3) @(negedge clk);
        chk("reset_col", 32'(col), 32'h0e);
        chk("reset_kv", 32'(keypad_val), 32'h00);
        chk("reset_bo", 32'(button_on), 32'h0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Idle sweep: each column for 4 cycles, wrapping 3 -> 0.
        for (int i = 0; i < 20; i++) begin
            chk("idle_col", 32'(col), 32'(pat[(i / 4) % 4]));
            chk("idle_out", 32'({button_on, keypad_val}), 32'h0);
            @(negedge clk);
        end

        // Single press and release of (1,1).
        expect_ev(4'b1101, 8'b0010_0010, 1'b1);
        key[1][1] = 1'b1;
        wait_bo("press_11", 1'b1, 19, n);
        repeat (50) @(negedge clk);
        chk("held_col", 32'(col), 32'h0d);
        chk("held_kv", 32'(keypad_val), 32'h22);
        expect_ev(4'b1011, 8'h00, 1'b0);
        key[1][1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rel_2cyc_bo", 32'(button_on), 32'h1);
        @(negedge clk);
        chk("rel_3cyc_bo", 32'(button_on), 32'h0);
        chk("rel_3cyc_kv", 32'(keypad_val), 32'h00);
        chk("rel_3cyc_col", 32'(col), 32'h0b);

        // Row priority in column 3.
        expect_ev(4'b0111, 8'b0100_1000, 1'b1);
        key[2][3] = 1'b1;
        key[3][3] = 1'b1;
        wait_bo("press_prio", 1'b1, 19, n);
        repeat (5) @(negedge clk);
        key[3][3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("prio_kv_kept", 32'(keypad_val), 32'h48);
        chk("prio_col_kept", 32'(col), 32'h07);
        expect_ev(4'b1110, 8'h00, 1'b0);
        key[2][3] = 1'b0;
        wait_bo("rel_prio", 1'b0, 6, n);
        chk("rel_latency", 32'(n), 32'd3);

        // Column hand-off: (0,0) then (0,2).
        expect_ev(4'b1110, 8'b0001_0001, 1'b1);
        key[0][0] = 1'b1;
        key[0][2] = 1'b1;
        wait_bo("press_00", 1'b1, 19, n);
        repeat (10) @(negedge clk);
        expect_ev(4'b1101, 8'h00, 1'b0);
        expect_ev(4'b1011, 8'b0001_0100, 1'b1);
        key[0][0] = 1'b0;
        wait_bo("rel_00", 1'b0, 6, n);
        chk("handoff_rel_latency", 32'(n), 32'd3);
        wait_bo("relock_02", 1'b1, 19, n);
        chk("handoff_gap", 32'(n), 32'd8);

        // Reset while (3,0) is locked.
        repeat (5) @(negedge clk);
        expect_ev(4'b0111, 8'h00, 1'b0);
        key[0][2] = 1'b0;
        wait_bo("rel_02", 1'b0, 6, n);
        expect_ev(4'b1110, 8'b1000_0001, 1'b1);
        key[3][0] = 1'b1;
        wait_bo("press_30", 1'b1, 19, n);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        expect_ev(4'b1110, 8'h00, 1'b0);
        reset = 1'b0;
        #1;
        chk("async_rst_col", 32'(col), 32'h0e);
        chk("async_rst_bo", 32'(button_on), 32'h0);
        chk("async_rst_kv", 32'(keypad_val), 32'h00);
        @(negedge clk);
        expect_ev(4'b1110, 8'b1000_0001, 1'b1);
        reset = 1'b1;
        wait_bo("relock_30", 1'b1, 19, n);
        chk("relock_latency", 32'(n), 32'd4);

        // One-cycle glitch on row 1 away from the sampled cycle.
        repeat (5) @(negedge clk);
        expect_ev(4'b1101, 8'h00, 1'b0);
        key[3][0] = 1'b0;
        wait_bo("rel_30", 1'b0, 6, n);
        @(negedge clk);
        @(negedge clk);
        glitch[1] = 1'b1;
        @(negedge clk);
        glitch[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("glitch_no_lock", 32'(button_on), 32'h0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
